// File: rtl/rv32i_core_pkg.sv
// Shared core types for the integer register file: register address type,
// the hard-wired zero register and the even-parity helper used when the
// RV_REGFILE_PARITY_EN build option is defined.
package rv32i_core_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0] regaddr_t;

  localparam regaddr_t REG_ZERO = 5'd0;

  // Even parity over one register word (XOR of all data bits).
  function automatic logic rf_parity(input logic [XLEN-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rv32i_regfile_mp_if.sv
// Register file access bundle: read ports, write ports, long-latency issue
// and flush controls. The pipeline drives through 'master', the register
// file receives through 'slave'.
interface rv32i_regfile_mp_if
  import rv32i_core_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int NRD_P  = 4,
  parameter int NWR_P  = 2
);

  regaddr_t [NRD_P-1:0]              rs_addr;
  logic     [NRD_P-1:0][XLEN_P-1:0]  rs_data;
  logic     [NRD_P-1:0]              rs_busy;
  logic     [NWR_P-1:0]              wr_en;
  regaddr_t [NWR_P-1:0]              wr_addr;
  logic     [NWR_P-1:0][XLEN_P-1:0]  wr_data;
  logic                              iss_en;
  regaddr_t                          iss_addr;
  logic                              flush;
  logic     [NRD_P-1:0]              par_err;

  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rs_data, rs_busy, par_err
  );

  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rs_data, rs_busy, par_err
  );

endinterface

// File: rtl/rv32i_regfile_scoreboard.sv
// Busy-bit scoreboard for registers with an outstanding long-latency write.
// Priority per register: flush clears, issue sets (beats a same-cycle
// write), a write clears, otherwise hold. The busy lookup hides a bit
// whose register is being written this very cycle.
module rv32i_regfile_scoreboard
  import rv32i_core_pkg::*;
#(
  parameter int NREGS_P = 32,
  parameter int NRD_P   = 4,
  parameter int NWR_P   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  iss_en_i,
  input  regaddr_t              iss_addr_i,
  input  logic     [NWR_P-1:0]  wr_en_i,
  input  regaddr_t [NWR_P-1:0]  wr_addr_i,
  input  regaddr_t [NRD_P-1:0]  rs_addr_i,
  output logic     [NRD_P-1:0]  rs_busy_o
);

  localparam int AW = $clog2(NREGS_P);

  logic [NREGS_P-1:0] busy_r;
  logic [NREGS_P-1:0] busy_s;
  logic [NREGS_P-1:0] wr_hit_s;
  logic [NRD_P-1:0]   rd_clr_s;

  // Decode which architectural registers receive a write this cycle.
  always_comb begin
    for (int r = 0; r < NREGS_P; r++) begin
      wr_hit_s[r] = 1'b0;
      for (int k = 0; k < NWR_P; k++) begin
        wr_hit_s[r] = wr_hit_s[r] | (wr_en_i[k] && (wr_addr_i[k] == regaddr_t'(r)));
      end
    end
  end

  // Next busy vector: flush, then issue-set, then write-clear, then hold.
  always_comb begin
    busy_s = busy_r;
    for (int r = 0; r < NREGS_P; r++) begin
      if (flush_i) begin
        busy_s[r] = 1'b0;
      end else if (iss_en_i && (r != 0) && (iss_addr_i == regaddr_t'(r))) begin
        busy_s[r] = 1'b1;
      end else if (wr_hit_s[r]) begin
        busy_s[r] = 1'b0;
      end else begin
        busy_s[r] = busy_r[r];
      end
    end
  end

  // Busy bit register; reset drops any issue presented in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_s;
    end
  end

  // Per-port busy lookup with the same-cycle write-clear bypassed.
  always_comb begin
    rs_busy_o = '0;
    rd_clr_s  = '0;
    for (int i = 0; i < NRD_P; i++) begin
      for (int k = 0; k < NWR_P; k++) begin
        rd_clr_s[i] = rd_clr_s[i] | (wr_en_i[k] && (wr_addr_i[k] == rs_addr_i[i]));
      end
      if ({27'd0, rs_addr_i[i]} < 32'(NREGS_P)) begin
        rs_busy_o[i] = busy_r[rs_addr_i[i][AW-1:0]] && !rd_clr_s[i];
      end else begin
        rs_busy_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rv32i_regfile_mp.sv
// Multi-port integer register file with write-tracking scoreboard.
// x0 is hard-wired to zero; addresses >= NREGS_P are ignored on write and
// read back as zero. Every read port bypasses same-cycle write data, the
// youngest (highest-index) write port winning.
// Build option RV_REGFILE_PARITY_EN adds a stored even-parity bit per
// register and a registered per-port parity error flag.
module rv32i_regfile_mp
  import rv32i_core_pkg::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int NREGS_P = 32,
  parameter int NRD_P   = 4,
  parameter int NWR_P   = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rv32i_regfile_mp_if.slave   bus
);

  localparam int AW = $clog2(NREGS_P);

  logic [XLEN_P-1:0]             regs_r [NREGS_P];
  logic [NRD_P-1:0][XLEN_P-1:0]  rs_data_s;

  // True when the address names an implemented register.
  function automatic logic addr_ok(input regaddr_t a);
    return ({27'd0, a} < 32'(NREGS_P));
  endfunction

  // Register storage: reset clears, later write ports override earlier ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS_P; r++) begin
        regs_r[r] <= '0;
      end
    end else begin
      for (int k = 0; k < NWR_P; k++) begin
        if (bus.wr_en[k] && (bus.wr_addr[k] != REG_ZERO) && addr_ok(bus.wr_addr[k])) begin
          regs_r[bus.wr_addr[k][AW-1:0]] <= bus.wr_data[k];
        end
      end
    end
  end

  // Read muxes: stored value, overridden by the youngest matching write.
  always_comb begin
    rs_data_s = '0;
    for (int i = 0; i < NRD_P; i++) begin
      if ((bus.rs_addr[i] != REG_ZERO) && addr_ok(bus.rs_addr[i])) begin
        rs_data_s[i] = regs_r[bus.rs_addr[i][AW-1:0]];
        for (int k = 0; k < NWR_P; k++) begin
          if (bus.wr_en[k] && (bus.wr_addr[k] == bus.rs_addr[i])) begin
            rs_data_s[i] = bus.wr_data[k];
          end else begin
            rs_data_s[i] = rs_data_s[i];
          end
        end
      end else begin
        rs_data_s[i] = '0;
      end
    end
  end

  assign bus.rs_data = rs_data_s;

  rv32i_regfile_scoreboard #(
    .NREGS_P (NREGS_P),
    .NRD_P   (NRD_P),
    .NWR_P   (NWR_P)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (bus.flush),
    .iss_en_i   (bus.iss_en),
    .iss_addr_i (bus.iss_addr),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .rs_addr_i  (bus.rs_addr),
    .rs_busy_o  (bus.rs_busy)
  );

`ifdef RV_REGFILE_PARITY_EN
  logic [NREGS_P-1:0] par_r;
  logic [NRD_P-1:0]   par_err_r;
  logic [NRD_P-1:0]   rd_stored_s;

  // Parity bits track the register storage write for write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_r <= '0;
    end else begin
      for (int k = 0; k < NWR_P; k++) begin
        if (bus.wr_en[k] && (bus.wr_addr[k] != REG_ZERO) && addr_ok(bus.wr_addr[k])) begin
          par_r[bus.wr_addr[k][AW-1:0]] <= rf_parity(bus.wr_data[k]);
        end
      end
    end
  end

  // Flag reads served from storage (not x0, not out of range, not bypassed).
  always_comb begin
    rd_stored_s = '0;
    for (int i = 0; i < NRD_P; i++) begin
      rd_stored_s[i] = (bus.rs_addr[i] != REG_ZERO) && addr_ok(bus.rs_addr[i]);
      for (int k = 0; k < NWR_P; k++) begin
        if (bus.wr_en[k] && (bus.wr_addr[k] == bus.rs_addr[i])) begin
          rd_stored_s[i] = 1'b0;
        end else begin
          rd_stored_s[i] = rd_stored_s[i];
        end
      end
    end
  end

  // Parity check on stored reads, reported one cycle later as a pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_err_r <= '0;
    end else begin
      for (int i = 0; i < NRD_P; i++) begin
        par_err_r[i] <= rd_stored_s[i] &&
                        (rf_parity(regs_r[bus.rs_addr[i][AW-1:0]]) != par_r[bus.rs_addr[i][AW-1:0]]);
      end
    end
  end

  assign bus.par_err = par_err_r;
`else
  assign bus.par_err = '0;
`endif

endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// Directed, table-driven bench for rv32i_regfile_mp (default 4R/2W, 32 regs).
module tb_rv32i_regfile_mp;
  import rv32i_core_pkg::*;

  typedef struct packed {
    logic [3:0][4:0]   rs;
    logic [1:0]        we;
    logic [1:0][4:0]   wa;
    logic [1:0][31:0]  wd;
    logic              ie;
    logic [4:0]        ia;
    logic              fl;
    logic [3:0][31:0]  ed;
    logic [3:0]        eb;
  } vec_t;

  localparam int NV = 17;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl [NV];
  logic [31:0] par_snap;

  rv32i_regfile_mp_if bus ();

  rv32i_regfile_mp dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [19:0] rs, input logic [1:0] we,
                              input logic [9:0] wa, input logic [63:0] wd,
                              input logic ie, input logic [4:0] ia, input logic fl,
                              input logic [127:0] ed, input logic [3:0] eb);
    vec_t v;
    v.rs = rs; v.we = we; v.wa = wa; v.wd = wd;
    v.ie = ie; v.ia = ia; v.fl = fl; v.ed = ed; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.rs_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bus.rs_addr  = v.rs;
    bus.wr_en    = v.we;
    bus.wr_addr  = v.wa;
    bus.wr_data  = v.wd;
    bus.iss_en   = v.ie;
    bus.iss_addr = v.ia;
    bus.flush    = v.fl;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // rs = {rs3,rs2,rs1,rs0}; wa/wd = {port1,port0}; ed = {d3,d2,d1,d0}
    tbl[0]  = mk({5'd5,5'd1,5'd0,5'd5}, 2'b11, {5'd5,5'd5}, {32'h22,32'h11}, 1'b0, 5'd0, 1'b0,
                 {32'h22,32'h0,32'h0,32'h22}, 4'b0000);
    tbl[1]  = mk({5'd0,5'd0,5'd6,5'd5}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0, 1'b0,
                 {32'h0,32'h0,32'h0,32'h22}, 4'b0000);
    tbl[2]  = mk(20'd0, 2'b11, {5'd0,5'd0}, {32'hFFFF_FFFF,32'hFFFF_FFFF}, 1'b1, 5'd0, 1'b0,
                 128'd0, 4'b0000);
    tbl[3]  = mk(20'd0, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0, 1'b0, 128'd0, 4'b0000);
    tbl[4]  = mk({5'd0,5'd0,5'd0,5'd7}, 2'b00, 10'd0, 64'd0, 1'b1, 5'd7, 1'b0, 128'd0, 4'b0000);
    tbl[5]  = mk({5'd0,5'd0,5'd7,5'd7}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0, 1'b0, 128'd0, 4'b0011);
    tbl[6]  = mk({5'd0,5'd0,5'd7,5'd7}, 2'b01, {5'd0,5'd7}, {32'h0,32'hABCD}, 1'b0, 5'd0, 1'b0,
                 {32'h0,32'h0,32'hABCD,32'hABCD}, 4'b0000);
    tbl[7]  = mk({5'd0,5'd0,5'd7,5'd7}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0, 1'b0,
                 {32'h0,32'h0,32'hABCD,32'hABCD}, 4'b0000);
    tbl[8]  = mk({5'd0,5'd0,5'd0,5'd9}, 2'b10, {5'd9,5'd0}, {32'h99,32'h0}, 1'b1, 5'd9, 1'b0,
                 {32'h0,32'h0,32'h0,32'h99}, 4'b0000);
    tbl[9]  = mk({5'd0,5'd0,5'd0,5'd9}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0, 1'b0,
                 {32'h0,32'h0,32'h0,32'h99}, 4'b0001);
    tbl[10] = mk({5'd0,5'd0,5'd9,5'd3}, 2'b00, 10'd0, 64'd0, 1'b1, 5'd3, 1'b0,
                 {32'h0,32'h0,32'h99,32'h0}, 4'b0010);
    tbl[11] = mk({5'd0,5'd0,5'd9,5'd3}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0, 1'b1,
                 {32'h0,32'h0,32'h99,32'h0}, 4'b0011);
    tbl[12] = mk({5'd0,5'd0,5'd9,5'd3}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0, 1'b0,
                 {32'h0,32'h0,32'h99,32'h0}, 4'b0000);
    tbl[13] = mk({5'd7,5'd5,5'd13,5'd12}, 2'b11, {5'd13,5'd12}, {32'hB,32'hA}, 1'b0, 5'd0, 1'b0,
                 {32'hABCD,32'h22,32'hB,32'hA}, 4'b0000);
    tbl[14] = mk({5'd0,5'd0,5'd0,5'd12}, 2'b00, 10'd0, 64'd0, 1'b1, 5'd12, 1'b1,
                 {32'h0,32'h0,32'h0,32'hA}, 4'b0000);
    tbl[15] = mk({5'd0,5'd0,5'd0,5'd12}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0, 1'b0,
                 {32'h0,32'h0,32'h0,32'hA}, 4'b0000);
    tbl[16] = mk({5'd12,5'd0,5'd13,5'd12}, 2'b11, {5'd12,5'd12}, {32'h2,32'h1}, 1'b0, 5'd0, 1'b0,
                 {32'h2,32'h0,32'hB,32'h2}, 4'b0000);

    // Reset
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_par_err", 128'(bus.par_err), 128'd0);

    // All ports sweep x1..x31 after reset
    for (int a = 1; a < 32; a++) begin
      bus.rs_addr = {4{5'(a)}};
      #1;
      chk($sformatf("reset_data_x%0d", a), 128'(bus.rs_data), 128'd0);
      chk($sformatf("reset_busy_x%0d", a), 128'(bus.rs_busy), 128'd0);
    end
    step();
    chk("reset_sweep_par_err", 128'(bus.par_err), 128'd0);

    // Directed vector table
    for (int j = 0; j < NV; j++) begin
      drive(tbl[j]);
      #1;
      chk($sformatf("vec%0d_data", j), 128'(bus.rs_data), tbl[j].ed);
      chk($sformatf("vec%0d_busy", j), 128'(bus.rs_busy), 128'(tbl[j].eb));
      step();
      chk($sformatf("vec%0d_par_err", j), 128'(bus.par_err), 128'd0);
    end

    // Reset mid-operation discards that cycle's write and issue
    idle();
    bus.wr_en    = 2'b01;
    bus.wr_addr  = {5'd0, 5'd20};
    bus.wr_data  = {32'h0, 32'h55};
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd21;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    bus.rs_addr = {5'd12, 5'd5, 5'd21, 5'd20};
    #1;
    chk("midrst_data", 128'(bus.rs_data), 128'd0);
    chk("midrst_busy", 128'(bus.rs_busy), 128'd0);
    step();
    chk("midrst_busy_next", 128'(bus.rs_busy), 128'd0);

`ifdef RV_REGFILE_PARITY_EN
    // Corrupted parity on x4: stored read flags port 2 for exactly one cycle
    idle();
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd4};
    bus.wr_data = {32'h0, 32'h1};
    step();
    idle();
    par_snap = dut.par_r;
    par_snap[4] = ~par_snap[4];
    force dut.par_r = par_snap;
    bus.rs_addr = {5'd0, 5'd4, 5'd0, 5'd0};
    #1;
    chk("par_data_x4", 128'(bus.rs_data), {32'h0, 32'h1, 32'h0, 32'h0});
    step();
    bus.rs_addr = '0;
    #1;
    chk("par_err_pulse", 128'(bus.par_err), 128'(4'b0100));
    step();
    chk("par_err_clear", 128'(bus.par_err), 128'd0);
    // Bypassed read of x4 skips the parity check
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd4};
    bus.wr_data = {32'h0, 32'h1};
    bus.rs_addr = {5'd0, 5'd4, 5'd0, 5'd0};
    step();
    idle();
    #1;
    chk("par_bypass_no_err", 128'(bus.par_err), 128'd0);
    release dut.par_r;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
